// File: rtl/usp_auth_pkg.sv
// Shared types and constants for the USP EV authentication hub.
// Holds the FSM state encoding, the response codes and the cipher keys.
package usp_auth_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REG      = 3'd1,
    VERIFY   = 3'd2,
    SEND_TAG = 3'd3,
    RESP     = 3'd4
  } state_e;

  localparam logic [2:0] RC_OK         = 3'd0;
  localparam logic [2:0] RC_AUTH_FAIL  = 3'd1;
  localparam logic [2:0] RC_REPLAY     = 3'd2;
  localparam logic [2:0] RC_DB_FULL    = 3'd3;
  localparam logic [2:0] RC_DUP        = 3'd4;
  localparam logic [2:0] RC_TIMEOUT    = 3'd5;
  localparam logic [2:0] RC_UNKNOWN_ID = 3'd6;

  localparam logic [63:0] DEC_KEY    = 64'hDEAD_BEEF_CAFE_BABE;
  localparam logic [63:0] TAG_KEY    = 64'hCAFE_BABE_DEAD_BEEF;
  localparam logic [63:0] AUTH_MAGIC = 64'h0000_0000_0000_005A;

  function automatic logic [63:0] decrypt(input logic [63:0] msg);
    return msg ^ DEC_KEY;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting just above the last accepted
// grant, wrapping around. The pointer only moves when advance_i is high.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_c_o,
  output logic [IDX_W-1:0] grant_idx_c_o,
  output logic             any_c_o
);

  logic [IDX_W-1:0] last_q;

  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_c_o     = '0;
    grant_idx_c_o = '0;
    any_c_o       = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (32'(last_q) + off) % N;
      if (!any_c_o && req_i[IDX_W'(idx)]) begin
        any_c_o                  = 1'b1;
        grant_c_o[IDX_W'(idx)]   = 1'b1;
        grant_idx_c_o            = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= IDX_W'(N - 1);
    end else if (advance_i && any_c_o) begin
      last_q <= grant_idx_c_o;
    end
  end

endmodule

// File: rtl/usp_auth_hub.sv
// EV authentication hub: arbitrates EV requests, keeps a registration table,
// verifies encrypted messages against it and hands tags to the charging station.
module usp_auth_hub
  import usp_auth_pkg::*;
#(
  parameter int unsigned NUM_EV   = 4,
  parameter int unsigned ID_W     = 16,
  parameter int unsigned DB_DEPTH = 8,
  parameter int unsigned TIMEOUT  = 255,
  localparam int unsigned CH_W    = (NUM_EV > 1) ? $clog2(NUM_EV) : 1,
  localparam int unsigned DBC_W   = $clog2(DB_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_EV-1:0]      req_valid,
  output logic [NUM_EV-1:0]      req_ready,
  input  logic [NUM_EV-1:0]      req_is_reg,
  input  logic [NUM_EV*ID_W-1:0] req_id,
  input  logic [NUM_EV*16-1:0]   req_nonce,
  input  logic [NUM_EV*64-1:0]   req_msg,
  input  logic [NUM_EV-1:0]      req_puf,
  output logic                   tag_valid,
  input  logic                   tag_ready,
  output logic [63:0]            tag,
  output logic                   rsp_valid,
  output logic [CH_W-1:0]        rsp_ch,
  output logic [2:0]             rsp_code,
  output logic [DBC_W-1:0]       db_count
);

  localparam int unsigned IDX_W = (DB_DEPTH > 1) ? $clog2(DB_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [CH_W-1:0]   cap_ch_q;
  logic [ID_W-1:0]   cap_id_q;
  logic [15:0]       cap_nonce_q;
  logic [63:0]       cap_msg_q;
  logic              cap_puf_q;
  logic [2:0]        code_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DB_DEPTH-1:0] tbl_valid_q;
  logic [ID_W-1:0]     tbl_id_q    [DB_DEPTH];
  logic [15:0]         tbl_nonce_q [DB_DEPTH];

  logic [NUM_EV-1:0] req_ready_q;
  logic              tag_valid_q;
  logic [63:0]       tag_q;
  logic              rsp_valid_q;
  logic [CH_W-1:0]   rsp_ch_q;
  logic [2:0]        rsp_code_q;
  logic [DBC_W-1:0]  db_count_q;

  logic [NUM_EV-1:0] grant_c;
  logic [CH_W-1:0]   grant_idx_c;
  logic              any_c;
  logic              advance_c;
  logic [ID_W-1:0]   sel_id_c;
  logic [15:0]       sel_nonce_c;
  logic [63:0]       sel_msg_c;
  logic              hit_c;
  logic [IDX_W-1:0]  hit_idx_c;
  logic              free_c;
  logic [IDX_W-1:0]  free_idx_c;
  logic [63:0]       dec_c;

  assign advance_c = (state_q == IDLE);

  rr_arbiter #(
    .N     (NUM_EV),
    .IDX_W (CH_W)
  ) u_arb (
    .clk_i         (clk),
    .rst_i         (reset),
    .req_i         (req_valid),
    .advance_i     (advance_c),
    .grant_c_o     (grant_c),
    .grant_idx_c_o (grant_idx_c),
    .any_c_o       (any_c)
  );

  // Payload of the channel currently winning arbitration.
  always_comb begin
    sel_id_c    = req_id[32'(grant_idx_c)*ID_W +: ID_W];
    sel_nonce_c = req_nonce[32'(grant_idx_c)*16 +: 16];
    sel_msg_c   = req_msg[32'(grant_idx_c)*64 +: 64];
  end

  // Associative match on the captured id, plus lowest free slot.
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int unsigned i = 0; i < DB_DEPTH; i++) begin
      if (tbl_valid_q[i] && (tbl_id_q[i] == cap_id_q)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
      if (!tbl_valid_q[i] && !free_c) begin
        free_c     = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
  end

  assign dec_c = decrypt(cap_msg_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cap_ch_q    <= '0;
      cap_id_q    <= '0;
      cap_nonce_q <= '0;
      cap_msg_q   <= '0;
      cap_puf_q   <= 1'b0;
      code_q      <= RC_OK;
      cnt_q       <= '0;
      tbl_valid_q <= '0;
      for (int unsigned i = 0; i < DB_DEPTH; i++) begin
        tbl_id_q[i]    <= '0;
        tbl_nonce_q[i] <= '0;
      end
      req_ready_q <= '0;
      tag_valid_q <= 1'b0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_code_q  <= RC_OK;
      db_count_q  <= '0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_c) begin
            req_ready_q <= grant_c;
            cap_ch_q    <= grant_idx_c;
            cap_id_q    <= sel_id_c;
            cap_nonce_q <= sel_nonce_c;
            cap_msg_q   <= sel_msg_c;
            cap_puf_q   <= req_puf[grant_idx_c];
            state_q     <= req_is_reg[grant_idx_c] ? REG : VERIFY;
          end
        end
        REG: begin
          if (hit_c) begin
            code_q <= RC_DUP;
          end else if (!free_c) begin
            code_q <= RC_DB_FULL;
          end else begin
            tbl_valid_q[free_idx_c] <= 1'b1;
            tbl_id_q[free_idx_c]    <= cap_id_q;
            tbl_nonce_q[free_idx_c] <= '0;
            db_count_q              <= db_count_q + DBC_W'(1);
            code_q                  <= RC_OK;
          end
          state_q <= RESP;
        end
        VERIFY: begin
          state_q <= RESP;
          if (!hit_c) begin
            code_q <= RC_UNKNOWN_ID;
          end else if (cap_nonce_q == tbl_nonce_q[hit_idx_c]) begin
            code_q <= RC_REPLAY;
          end else if ((dec_c[7:0] != AUTH_MAGIC[7:0]) || !cap_puf_q) begin
            code_q <= RC_AUTH_FAIL;
          end else begin
            tag_q                  <= dec_c ^ TAG_KEY;
            tag_valid_q            <= 1'b1;
            tbl_nonce_q[hit_idx_c] <= cap_nonce_q;
            cnt_q                  <= '0;
            state_q                <= SEND_TAG;
          end
        end
        SEND_TAG: begin
          // tag_valid_q is always set while in this state.
          if (tag_ready) begin
            code_q      <= RC_OK;
            tag_valid_q <= 1'b0;
            state_q     <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            code_q      <= RC_TIMEOUT;
            tag_valid_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_ch_q    <= cap_ch_q;
          rsp_code_q  <= code_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tag_valid = tag_valid_q;
  assign tag       = tag_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_code  = rsp_code_q;
  assign db_count  = db_count_q;

endmodule

// File: tb/tb_usp_auth_hub.sv
// Directed bench for usp_auth_hub: registration, authentication, arbitration,
// tag timeout and reset-during-tag scenarios with hand-computed expectations.
module tb_usp_auth_hub;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_is_reg;
  logic [63:0]  req_id;
  logic [63:0]  req_nonce;
  logic [255:0] req_msg;
  logic [3:0]   req_puf;
  logic         tag_valid;
  logic         tag_ready;
  logic [63:0]  tag;
  logic         rsp_valid;
  logic [1:0]   rsp_ch;
  logic [2:0]   rsp_code;
  logic [1:0]   db_count;

  int tests;
  int fails;

  localparam logic [63:0] KEY_D  = 64'hDEAD_BEEF_CAFE_BABE;
  localparam logic [63:0] KEY_T  = 64'hCAFE_BABE_DEAD_BEEF;
  localparam logic [63:0] PLAIN  = 64'h0123_4567_89AB_CD5A;
  localparam logic [63:0] BADPL  = 64'h0123_4567_89AB_CD00;

  usp_auth_hub #(
    .NUM_EV   (4),
    .ID_W     (16),
    .DB_DEPTH (2),
    .TIMEOUT  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_is_reg (req_is_reg),
    .req_id     (req_id),
    .req_nonce  (req_nonce),
    .req_msg    (req_msg),
    .req_puf    (req_puf),
    .tag_valid  (tag_valid),
    .tag_ready  (tag_ready),
    .tag        (tag),
    .rsp_valid  (rsp_valid),
    .rsp_ch     (rsp_ch),
    .rsp_code   (rsp_code),
    .db_count   (db_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one request, wait for its grant and its response strobe.
  task automatic do_req(input int ch, input bit is_reg, input logic [15:0] id,
                        input logic [15:0] nonce, input logic [63:0] msg, input bit puf,
                        output logic [2:0] code, output logic [1:0] rch, output int lat,
                        output int tvc, output logic [63:0] tg, output logic [3:0] rdy);
    bit got;
    @(negedge clk);
    req_id[ch*16 +: 16]    = id;
    req_nonce[ch*16 +: 16] = nonce;
    req_msg[ch*64 +: 64]   = msg;
    req_is_reg[ch]         = is_reg;
    req_puf[ch]            = puf;
    req_valid[ch]          = 1'b1;
    got = 1'b0;
    rdy = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        got = 1'b1;
        rdy = req_ready;
        break;
      end
    end
    req_valid[ch] = 1'b0;
    check("grant_seen", 64'(got), 64'd1);
    lat  = 0;
    tvc  = 0;
    tg   = '0;
    code = 3'b111;
    rch  = 2'b00;
    got  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      lat++;
      if (tag_valid) begin
        tvc++;
        tg = tag;
      end
      if (rsp_valid) begin
        got  = 1'b1;
        code = rsp_code;
        rch  = rsp_ch;
        break;
      end
    end
    check("rsp_seen", 64'(got), 64'd1);
  endtask

  initial begin
    logic [2:0]  code;
    logic [1:0]  rch;
    int          lat;
    int          tvc;
    logic [63:0] tg;
    logic [3:0]  rdy;
    int          order [6];
    bit          got;

    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_is_reg = '0;
    req_id     = '0;
    req_nonce  = '0;
    req_msg    = '0;
    req_puf    = '0;
    tag_ready  = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_tag_valid", 64'(tag_valid), 64'd0);
    check("rst_tag", tag, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_ch", 64'(rsp_ch), 64'd0);
    check("rst_rsp_code", 64'(rsp_code), 64'd0);
    check("rst_db_count", 64'(db_count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Registration and duplicate.
    do_req(0, 1'b1, 16'h00EF, 16'h0, 64'h0, 1'b0, code, rch, lat, tvc, tg, rdy);
    check("reg_grant", 64'(rdy), 64'h1);
    check("reg_latency", 64'(lat), 64'd2);
    check("reg_code", 64'(code), 64'd0);
    check("reg_ch", 64'(rch), 64'd0);
    check("reg_db_count", 64'(db_count), 64'd1);
    do_req(0, 1'b1, 16'h00EF, 16'h0, 64'h0, 1'b0, code, rch, lat, tvc, tg, rdy);
    check("dup_code", 64'(code), 64'd4);
    check("dup_latency", 64'(lat), 64'd2);
    check("dup_db_count", 64'(db_count), 64'd1);

    // Fill table then overflow.
    reset_dut();
    check("clr_db_count", 64'(db_count), 64'd0);
    do_req(1, 1'b1, 16'h0001, 16'h0, 64'h0, 1'b0, code, rch, lat, tvc, tg, rdy);
    check("reg1_code", 64'(code), 64'd0);
    check("reg1_grant", 64'(rdy), 64'h2);
    do_req(2, 1'b1, 16'h0002, 16'h0, 64'h0, 1'b0, code, rch, lat, tvc, tg, rdy);
    check("reg2_code", 64'(code), 64'd0);
    do_req(3, 1'b1, 16'h0003, 16'h0, 64'h0, 1'b0, code, rch, lat, tvc, tg, rdy);
    check("full_code", 64'(code), 64'd3);
    check("full_ch", 64'(rch), 64'd3);
    check("full_latency", 64'(lat), 64'd2);
    check("full_db_count", 64'(db_count), 64'd2);
    do_req(0, 1'b1, 16'h0001, 16'h0, 64'h0, 1'b0, code, rch, lat, tvc, tg, rdy);
    check("dup_over_full", 64'(code), 64'd4);

    // Authentication paths.
    tag_ready = 1'b1;
    do_req(1, 1'b0, 16'h0001, 16'hACE1, PLAIN ^ KEY_D, 1'b1, code, rch, lat, tvc, tg, rdy);
    check("auth_code", 64'(code), 64'd0);
    check("auth_tag", tg, PLAIN ^ KEY_T);
    check("auth_tag_cycles", 64'(tvc), 64'd1);
    check("auth_ch", 64'(rch), 64'd1);
    do_req(1, 1'b0, 16'h0001, 16'hACE1, PLAIN ^ KEY_D, 1'b1, code, rch, lat, tvc, tg, rdy);
    check("replay_code", 64'(code), 64'd2);
    check("replay_latency", 64'(lat), 64'd2);
    do_req(1, 1'b0, 16'h0001, 16'h1111, BADPL ^ KEY_D, 1'b1, code, rch, lat, tvc, tg, rdy);
    check("badmagic_code", 64'(code), 64'd1);
    check("badmagic_latency", 64'(lat), 64'd2);
    do_req(1, 1'b0, 16'h0001, 16'h2222, PLAIN ^ KEY_D, 1'b0, code, rch, lat, tvc, tg, rdy);
    check("puf0_code", 64'(code), 64'd1);
    check("puf0_no_tag", 64'(tvc), 64'd0);
    do_req(3, 1'b0, 16'h0003, 16'h3333, PLAIN ^ KEY_D, 1'b1, code, rch, lat, tvc, tg, rdy);
    check("unknown_code", 64'(code), 64'd6);
    check("unknown_ch", 64'(rch), 64'd3);
    do_req(2, 1'b0, 16'h0002, 16'h0000, PLAIN ^ KEY_D, 1'b1, code, rch, lat, tvc, tg, rdy);
    check("zero_nonce_code", 64'(code), 64'd2);

    // Round-robin order with wrap-around.
    reset_dut();
    order = '{0, 1, 2, 3, 0, 2};
    @(negedge clk);
    req_id     = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    req_is_reg = 4'b0000;
    req_valid  = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      rdy = '0;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (req_ready != 4'b0) begin
          got = 1'b1;
          rdy = req_ready;
          break;
        end
      end
      check("rr_grant", 64'(rdy), 64'(4'b0001 << order[k]));
      req_valid = req_valid & ~rdy;
      if (k == 3) req_valid = req_valid | 4'b0101;
      if (!got) break;
    end
    repeat (6) @(negedge clk);

    // Tag timeout.
    reset_dut();
    do_req(2, 1'b1, 16'h0005, 16'h0, 64'h0, 1'b0, code, rch, lat, tvc, tg, rdy);
    check("to_reg_code", 64'(code), 64'd0);
    tag_ready = 1'b0;
    do_req(2, 1'b0, 16'h0005, 16'h0042, PLAIN ^ KEY_D, 1'b1, code, rch, lat, tvc, tg, rdy);
    check("to_tag_cycles", 64'(tvc), 64'd8);
    check("to_code", 64'(code), 64'd5);
    check("to_ch", 64'(rch), 64'd2);
    check("to_tag", tg, PLAIN ^ KEY_T);

    // Reset while the tag is being offered.
    @(negedge clk);
    req_nonce[2*16 +: 16] = 16'h0043;
    req_is_reg[2] = 1'b0;
    req_valid[2]  = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[2]) begin
        got = 1'b1;
        break;
      end
    end
    req_valid[2] = 1'b0;
    check("mid_grant", 64'(got), 64'd1);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tag_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("mid_tag_up", 64'(got), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_tag_valid", 64'(tag_valid), 64'd0);
    check("mid_rst_db_count", 64'(db_count), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (rsp_valid || tag_valid) got = 1'b1;
    end
    check("mid_rst_quiet", 64'(got), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
